// File: rtl/k_and_s_pkg.sv
// Shared types for the K&S datapath: the decoded instruction enumeration
// produced by the fetch unit and consumed by the control FSM.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_BRANCH = 4'd1,
        I_BZERO  = 4'd2,
        I_BNZERO = 4'd3,
        I_BNEG   = 4'd4,
        I_BNNEG  = 4'd5,
        I_LOAD   = 4'd6,
        I_STORE  = 4'd7,
        I_MOVE   = 4'd8,
        I_ADD    = 4'd9,
        I_SUB    = 4'd10,
        I_AND    = 4'd11,
        I_OR     = 4'd12,
        I_HALT   = 4'd13
    } decoded_instruction_type;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, instruction register, flags register, IR decode
// and RAM address mux, all qualified by the control FSM enables.
// Optional feature: define ILLEGAL_OP_TRAP_EN to decode unlisted opcodes as
// I_HALT and expose a sticky illegal_op output (cleared only by rst).
module instruction_fetch_unit
    import k_and_s_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 5,
    parameter int unsigned           DATA_W   = 16,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pc_enable,
    input  logic                    branch,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    flags_reg_enable,
    input  logic [DATA_W-1:0]       ram_rdata,
    input  logic                    alu_zero,
    input  logic                    alu_neg,
    input  logic                    alu_uovf,
    input  logic                    alu_sovf,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [ADDR_W-1:0]       pc,
    output decoded_instruction_type decoded_instruction,
    output logic [1:0]              a_addr,
    output logic [1:0]              b_addr,
    output logic [1:0]              c_addr,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic                    signed_overflow,
    output logic                    illegal_op
`else
    output logic                    signed_overflow
`endif
);

    logic [15:0]       ir;
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] mem_field;
    logic              unused_ir_bit;

    assign opcode        = ir[15:8];
    assign mem_field     = ir[ADDR_W-1:0];
    assign unused_ir_bit = ir[7];

    // True when an opcode byte is one of the defined instructions.
    function automatic logic is_legal(input logic [7:0] op);
        case (op)
            8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
            8'h81, 8'h82, 8'h91,
            8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    // PC and IR update together from their pre-edge values, so a branch
    // issued alongside an IR load targets the old IR's address field.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            ir <= '0;
        end else begin
            if (ir_enable) begin
                ir <= ram_rdata[15:0];
            end
            if (pc_enable) begin
                if (branch) begin
                    pc <= mem_field;
                end else begin
                    pc <= pc + ADDR_W'(1);
                end
            end
        end
    end

    // Flags register: all four ALU flags captured together or held.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= alu_zero;
            neg_op            <= alu_neg;
            unsigned_overflow <= alu_uovf;
            signed_overflow   <= alu_sovf;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    // Sticky trap: sets on the edge an unlisted opcode enters the IR.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (ir_enable && !is_legal(ram_rdata[15:8])) begin
            illegal_op <= 1'b1;
        end
    end
`endif

    // RAM address mux: PC for fetch, IR address field for data access.
    always_comb begin
        ram_addr = addr_sel ? pc : mem_field;
    end

    // Combinational decode of the IR into instruction and register indices.
    always_comb begin
        decoded_instruction = I_NOP;
        a_addr              = '0;
        b_addr              = '0;
        c_addr              = '0;
        case (opcode)
            8'h00: decoded_instruction = I_NOP;
            8'h01: decoded_instruction = I_BRANCH;
            8'h02: decoded_instruction = I_BZERO;
            8'h03: decoded_instruction = I_BNZERO;
            8'h04: decoded_instruction = I_BNEG;
            8'h05: decoded_instruction = I_BNNEG;
            8'h81, 8'h82: begin
                decoded_instruction = (opcode == 8'h81) ? I_LOAD : I_STORE;
                a_addr              = ir[6:5];
                c_addr              = ir[6:5];
            end
            8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
                case (opcode)
                    8'h91:   decoded_instruction = I_MOVE;
                    8'hA1:   decoded_instruction = I_ADD;
                    8'hA2:   decoded_instruction = I_SUB;
                    8'hA3:   decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                a_addr = ir[5:4];
                b_addr = ir[3:2];
                c_addr = ir[1:0];
            end
            8'hFF: decoded_instruction = I_HALT;
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                decoded_instruction = I_HALT;
`else
                decoded_instruction = I_NOP;
`endif
            end
        endcase
    end

`ifndef ILLEGAL_OP_TRAP_EN
    logic unused_legal_fn;
    assign unused_legal_fn = is_legal(opcode);
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: expected values are pushed
// to a scoreboard queue as stimulus is driven and popped after the edge.
module tb_instruction_fetch_unit;
    import k_and_s_pkg::*;

    logic        clk = 1'b0;
    logic        rst, pc_enable, branch, ir_enable, addr_sel, flags_reg_enable;
    logic [15:0] ram_rdata;
    logic        alu_zero, alu_neg, alu_uovf, alu_sovf;
    logic [4:0]  ram_addr, pc;
    decoded_instruction_type decoded_instruction;
    logic [1:0]  a_addr, b_addr, c_addr;
    logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        illegal_op;
`endif

    instruction_fetch_unit #(.ADDR_W(5), .DATA_W(16), .RESET_PC(5'd0)) dut (
        .clk(clk), .rst(rst), .pc_enable(pc_enable), .branch(branch),
        .ir_enable(ir_enable), .addr_sel(addr_sel),
        .flags_reg_enable(flags_reg_enable), .ram_rdata(ram_rdata),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_uovf(alu_uovf),
        .alu_sovf(alu_sovf), .ram_addr(ram_addr), .pc(pc),
        .decoded_instruction(decoded_instruction),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
        .zero_op(zero_op), .neg_op(neg_op),
        .unsigned_overflow(unsigned_overflow),
`ifdef ILLEGAL_OP_TRAP_EN
        .signed_overflow(signed_overflow),
        .illegal_op(illegal_op)
`else
        .signed_overflow(signed_overflow)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] sb[$];
    logic [15:0] e;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_enable = 1'b0; branch = 1'b0; ir_enable = 1'b0;
        flags_reg_enable = 1'b0; addr_sel = 1'b1;
    endtask

    task automatic load_ir(input logic [15:0] word);
        ram_rdata = word; ir_enable = 1'b1;
        tick();
        ir_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pc_enable = 1'($urandom_range(0, 1));
        branch = 1'($urandom_range(0, 1));
        ir_enable = 1'b1;
        flags_reg_enable = 1'b1;
        ram_rdata = 16'hA11B;
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b1111;
        addr_sel = 1'b1;
        sb.push_back(16'd0);                 // pc
        sb.push_back(16'(I_NOP));            // decoded
        sb.push_back(16'd0);                 // flags
        sb.push_back(16'd0);                 // ram_addr
        tick();
        rst = 1'b0;
        idle_inputs();
        e = sb.pop_front(); vectors++;
        if ({11'd0, pc} !== e) begin
            $display("FAIL reset_pc got=%0d exp=%0d", pc, e); miscompares++;
        end
        e = sb.pop_front(); vectors++;
        if ({12'd0, decoded_instruction} !== e) begin
            $display("FAIL reset_decode got=%0d exp=%0d", decoded_instruction, e); miscompares++;
        end
        e = sb.pop_front(); vectors++;
        if ({12'd0, zero_op, neg_op, unsigned_overflow, signed_overflow} !== e) begin
            $display("FAIL reset_flags got=%b%b%b%b exp=%0d", zero_op, neg_op,
                     unsigned_overflow, signed_overflow, e); miscompares++;
        end
        e = sb.pop_front(); vectors++;
        if ({11'd0, ram_addr} !== e) begin
            $display("FAIL reset_ram_addr got=%0d exp=%0d", ram_addr, e); miscompares++;
        end
`ifdef ILLEGAL_OP_TRAP_EN
        vectors++;
        if (illegal_op !== 1'b0) begin
            $display("FAIL reset_illegal got=%b exp=0", illegal_op); miscompares++;
        end
`endif
    endtask

    typedef struct {
        logic [15:0] word;
        logic [3:0]  dec;
        logic [5:0]  abc;
    } dec_vec_t;

    task automatic test_decode();
        dec_vec_t tbl[14];
        tbl[0]  = '{16'h0000, 4'(I_NOP),    6'b00_00_00};
        tbl[1]  = '{16'h01FF, 4'(I_BRANCH), 6'b00_00_00};
        tbl[2]  = '{16'h0233, 4'(I_BZERO),  6'b00_00_00};
        tbl[3]  = '{16'h0344, 4'(I_BNZERO), 6'b00_00_00};
        tbl[4]  = '{16'h0455, 4'(I_BNEG),   6'b00_00_00};
        tbl[5]  = '{16'h0566, 4'(I_BNNEG),  6'b00_00_00};
        tbl[6]  = '{16'h8147, 4'(I_LOAD),   6'b10_00_10};
        tbl[7]  = '{16'h8227, 4'(I_STORE),  6'b01_00_01};
        tbl[8]  = '{16'h9127, 4'(I_MOVE),   6'b10_01_11};
        tbl[9]  = '{16'hA11B, 4'(I_ADD),    6'b01_10_11};
        tbl[10] = '{16'hA2E4, 4'(I_SUB),    6'b10_01_00};
        tbl[11] = '{16'hA31E, 4'(I_AND),    6'b01_11_10};
        tbl[12] = '{16'hA439, 4'(I_OR),     6'b11_10_01};
        tbl[13] = '{16'hFFFF, 4'(I_HALT),   6'b00_00_00};
        for (int i = 0; i < 14; i++) begin
            sb.push_back({12'd0, tbl[i].dec});
            sb.push_back({10'd0, tbl[i].abc});
            load_ir(tbl[i].word);
            e = sb.pop_front(); vectors++;
            if ({12'd0, decoded_instruction} !== e) begin
                $display("FAIL decode_%h got=%0d exp=%0d", tbl[i].word,
                         decoded_instruction, e); miscompares++;
            end
            e = sb.pop_front(); vectors++;
            if ({10'd0, a_addr, b_addr, c_addr} !== e) begin
                $display("FAIL fields_%h got=%b exp=%b", tbl[i].word,
                         {a_addr, b_addr, c_addr}, e[5:0]); miscompares++;
            end
        end
    endtask

    task automatic test_pc();
        // Branch to 31 via IR field, then increment must wrap to 0.
        load_ir(16'h011F);
        pc_enable = 1'b1; branch = 1'b1;
        sb.push_back(16'd31);
        tick();
        e = sb.pop_front(); vectors++;
        if ({11'd0, pc} !== e) begin
            $display("FAIL pc_branch31 got=%0d exp=%0d", pc, e); miscompares++;
        end
        branch = 1'b0;
        sb.push_back(16'd0);
        tick();
        e = sb.pop_front(); vectors++;
        if ({11'd0, pc} !== e) begin
            $display("FAIL pc_wrap got=%0d exp=%0d", pc, e); miscompares++;
        end
        pc_enable = 1'b0;
        load_ir(16'h010A);
        // branch without pc_enable: hold
        branch = 1'b1;
        sb.push_back(16'd0);
        tick();
        e = sb.pop_front(); vectors++;
        if ({11'd0, pc} !== e) begin
            $display("FAIL pc_branch_alone got=%0d exp=%0d", pc, e); miscompares++;
        end
        pc_enable = 1'b1;
        sb.push_back(16'd10);
        tick();
        e = sb.pop_front(); vectors++;
        if ({11'd0, pc} !== e) begin
            $display("FAIL pc_branch10 got=%0d exp=%0d", pc, e); miscompares++;
        end
        branch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(16'(11 + i));
            tick();
            e = sb.pop_front(); vectors++;
            if ({11'd0, pc} !== e) begin
                $display("FAIL pc_incr got=%0d exp=%0d", pc, e); miscompares++;
            end
        end
        pc_enable = 1'b0;
    endtask

    task automatic test_ram_addr();
        load_ir(16'h8247);
        addr_sel = 1'b0;
        #1;
        sb.push_back(16'd7);
        sb.push_back(16'd2);
        e = sb.pop_front(); vectors++;
        if ({11'd0, ram_addr} !== e) begin
            $display("FAIL ram_addr_mem got=%0d exp=%0d", ram_addr, e); miscompares++;
        end
        e = sb.pop_front(); vectors++;
        if ({14'd0, a_addr} !== e) begin
            $display("FAIL store_a_addr got=%0d exp=%0d", a_addr, e); miscompares++;
        end
        addr_sel = 1'b1;
        #1;
        sb.push_back(16'd13);               // PC left at 13 by test_pc
        e = sb.pop_front(); vectors++;
        if ({11'd0, ram_addr} !== e) begin
            $display("FAIL ram_addr_pc got=%0d exp=%0d", ram_addr, e); miscompares++;
        end
    endtask

    task automatic test_flags();
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b1000;
        flags_reg_enable = 1'b0;
        sb.push_back(16'd0);
        tick();
        e = sb.pop_front(); vectors++;
        if ({15'd0, zero_op} !== e) begin
            $display("FAIL flags_hold_zero got=%b exp=%0d", zero_op, e); miscompares++;
        end
        flags_reg_enable = 1'b1;
        sb.push_back(16'b1000);
        tick();
        flags_reg_enable = 1'b0;
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b0111;
        e = sb.pop_front(); vectors++;
        if ({12'd0, zero_op, neg_op, unsigned_overflow, signed_overflow} !== e) begin
            $display("FAIL flags_capture got=%b%b%b%b exp=%b", zero_op, neg_op,
                     unsigned_overflow, signed_overflow, e[3:0]); miscompares++;
        end
        sb.push_back(16'b1000);
        tick();
        e = sb.pop_front(); vectors++;
        if ({12'd0, zero_op, neg_op, unsigned_overflow, signed_overflow} !== e) begin
            $display("FAIL flags_hold got=%b%b%b%b exp=%b", zero_op, neg_op,
                     unsigned_overflow, signed_overflow, e[3:0]); miscompares++;
        end
        flags_reg_enable = 1'b1;
        sb.push_back(16'b0111);
        tick();
        flags_reg_enable = 1'b0;
        e = sb.pop_front(); vectors++;
        if ({12'd0, zero_op, neg_op, unsigned_overflow, signed_overflow} !== e) begin
            $display("FAIL flags_capture2 got=%b%b%b%b exp=%b", zero_op, neg_op,
                     unsigned_overflow, signed_overflow, e[3:0]); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        load_ir(16'h0114);                   // branch target 20
        ram_rdata = 16'h0103;                // next IR, target 3
        ir_enable = 1'b1; pc_enable = 1'b1; branch = 1'b1;
        sb.push_back(16'd20);
        sb.push_back(16'd3);
        tick();
        ir_enable = 1'b0; pc_enable = 1'b0; branch = 1'b0;
        e = sb.pop_front(); vectors++;
        if ({11'd0, pc} !== e) begin
            $display("FAIL b2b_old_target got=%0d exp=%0d", pc, e); miscompares++;
        end
        addr_sel = 1'b0;
        #1;
        e = sb.pop_front(); vectors++;
        if ({11'd0, ram_addr} !== e) begin
            $display("FAIL b2b_new_ir got=%0d exp=%0d", ram_addr, e); miscompares++;
        end
        addr_sel = 1'b1;
    endtask

    task automatic test_reset_mid();
        load_ir(16'hA11B);
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b1111;
        flags_reg_enable = 1'b1;
        tick();
        rst = 1'b1; pc_enable = 1'b1; ir_enable = 1'b1; ram_rdata = 16'hA2E4;
        sb.push_back({5'd0, 4'(I_NOP), 4'd0, 3'd0});
        tick();
        rst = 1'b0;
        idle_inputs();
        e = sb.pop_front(); vectors++;
        if ({pc[4:0], 2'd0, decoded_instruction, zero_op, neg_op,
             unsigned_overflow, signed_overflow, 3'd0} !== e) begin
            $display("FAIL reset_mid got pc=%0d dec=%0d flags=%b%b%b%b exp=%h", pc,
                     decoded_instruction, zero_op, neg_op, unsigned_overflow,
                     signed_overflow, e); miscompares++;
        end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_OP_TRAP_EN
        // Unlisted opcode on ram_rdata without ir_enable must not trap.
        ram_rdata = 16'h7700;
        sb.push_back(16'd0);
        tick();
        e = sb.pop_front(); vectors++;
        if ({15'd0, illegal_op} !== e) begin
            $display("FAIL illegal_no_load got=%b exp=%0d", illegal_op, e); miscompares++;
        end
        sb.push_back(16'(I_HALT));
        sb.push_back(16'd1);
        load_ir(16'h7700);
        e = sb.pop_front(); vectors++;
        if ({12'd0, decoded_instruction} !== e) begin
            $display("FAIL illegal_decode got=%0d exp=%0d", decoded_instruction, e); miscompares++;
        end
        e = sb.pop_front(); vectors++;
        if ({15'd0, illegal_op} !== e) begin
            $display("FAIL illegal_set got=%b exp=%0d", illegal_op, e); miscompares++;
        end
        sb.push_back(16'd1);
        load_ir(16'hA11B);
        e = sb.pop_front(); vectors++;
        if ({15'd0, illegal_op} !== e) begin
            $display("FAIL illegal_sticky got=%b exp=%0d", illegal_op, e); miscompares++;
        end
        rst = 1'b1;
        sb.push_back(16'd0);
        tick();
        rst = 1'b0;
        e = sb.pop_front(); vectors++;
        if ({15'd0, illegal_op} !== e) begin
            $display("FAIL illegal_clear got=%b exp=%0d", illegal_op, e); miscompares++;
        end
`else
        sb.push_back(16'(I_NOP));
        sb.push_back(16'd0);
        load_ir(16'h7700);
        e = sb.pop_front(); vectors++;
        if ({12'd0, decoded_instruction} !== e) begin
            $display("FAIL unlisted_decode got=%0d exp=%0d", decoded_instruction, e); miscompares++;
        end
        e = sb.pop_front(); vectors++;
        if ({10'd0, a_addr, b_addr, c_addr} !== e) begin
            $display("FAIL unlisted_fields got=%b exp=0", {a_addr, b_addr, c_addr}); miscompares++;
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        ram_rdata = '0;
        {alu_zero, alu_neg, alu_uovf, alu_sovf} = 4'b0000;
        test_reset();
        test_decode();
        test_pc();
        test_ram_addr();
        test_flags();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
